ntt_butterfly_pipe: RTL and testbench
=====================================

Name: ntt_butterfly_pipe

Overview:
- Pipelined Cooley-Tukey butterfly, the NTT stage that drives the modular subtractor.
- Computes t = zeta*b mod q, then a' = (a + t) mod q and b' = (a - t) mod q.
- Sits between the coefficient RAM read port and the RAM write-back path.
- Fully pipelined with a valid/ready handshake: one butterfly per cycle, latency 3.

Parameters:
- DW, `DWIDTH (12), coefficient width.
- Q, `KYBER_Q (3329), modulus.
- BAR_M, 5039, Barrett constant, floor(2^24/Q).
- BAR_K, 24, Barrett shift.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  stage accepts input this cycle.
- in_a  in  DW  coefficient a, range 0..Q-1.
- in_b  in  DW  coefficient b, range 0..Q-1.
- in_zeta  in  DW  twiddle factor, range 0..Q-1.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- out_a  out  DW  (a + zeta*b) mod Q.
- out_b  out  DW  (a - zeta*b) mod Q.
- in_mode  in  1  0 = CT, 1 = GS. Present only when NTT_GS_MODE_EN is defined.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: all stage valid bits 0, out_valid=0, out_a=0, out_b=0. Data registers need not be reset.
- Global enable: adv = !out_valid | out_ready; in_ready = adv, combinational.
- When adv=0, every stage register holds.
- Transfer: an input transfers when in_valid & in_ready. An output transfers when out_valid & out_ready.
- Stage 1: p = in_b*in_zeta (2*DW bits, < Q^2 < 2^24). Register p and in_a; v1 <= in_valid.
- Stage 2: Barrett reduction.
  - qh = (p*BAR_M) >> BAR_K.
  - r = p - qh*Q, which lies in 0..2Q-1.
  - t = (r >= Q) ? r-Q : r.
  - Register t and a; v2 <= v1.
- Stage 3:
  - out_a <= (a+t >= Q) ? a+t-Q : a+t.
  - out_b <= (a >= t) ? a-t : a+Q-t.
  - out_valid <= v2.
- Latency: exactly 3 cycles from input transfer to out_valid when out_ready is held high.
- Throughput: 1 butterfly per cycle.
- Ordering: strict FIFO order; no reordering or dropping. Back-to-back inputs produce back-to-back outputs.
- Backpressure: out_ready=0 with out_valid=1 freezes the whole pipeline. in_ready drops in the same cycle.
- Bubbles: the stage valid bits propagate bubbles, so invalid slots never assert out_valid.
- Wrap cases:
  - a+t = Q exactly must give out_a = 0.
  - a = t must give out_b = 0.
  - a < t must wrap upward.
- Out-of-range inputs (>= Q) are undefined; no checking.
- Reset asserted mid-operation: in-flight results are discarded and out_valid goes to 0 immediately (asynchronous).
- After rst_n deasserts, in_ready=1 on the first clock.

Optional Feature:
- Macro: NTT_GS_MODE_EN.
- Defined:
  - The in_mode port exists and is carried down the pipeline with its data.
  - Mode 1 (Gentleman-Sande inverse butterfly): out_a = (a+b) mod Q, out_b = ((a-b) mod Q)*zeta mod Q.
  - Latency is 3 in both modes, and modes may alternate every cycle.
- Undefined: no in_mode port; CT only; the GS datapath muxes are absent.

Decomposition:
- The shared defines header holds:
  - DWIDTH and KYBER_Q;
  - KYBER_BARRETT_M (5039) and KYBER_BARRETT_K (24);
  - NTT_LATENCY (3).
- One natural sub-module: barrett_reduce, combinational, 24-bit in, DW out in 0..Q-1. It is used in stage 2 and is reusable by the pointwise multiplier.
- The final add and subtract reuse the existing modular add/subtract cells.

Test Plan:
- a=100, b=200, zeta=17, out_ready=1 -> 3 cycles later out_a=171, out_b=29.
- a=0, b=3328, zeta=3328 (p=11075584, t=1) -> out_a=1, out_b=3328.
- a=3328, b=1, zeta=1 -> out_a=0 (wrap at Q), out_b=3327.
- Streaming and stall:
  - Stimulus: 8 back-to-back random inputs, with out_ready=0 for cycles 4-6.
  - Response: no loss, duplication or reorder; in_ready=0 while stalled; outputs match the golden model.
- Reset mid-stream:
  - Stimulus: rst_n low with 2 items in flight.
  - Response: out_valid=0 immediately; no stale results after release.
- GS (macro defined): mode=1, a=5, b=10, zeta=2 -> out_a=15, out_b=3319; interleaved CT/GS stream matches the model.

Source files
------------

// File: rtl/ntt_butterfly_pipe_pkg.sv
// ntt_butterfly_pipe_pkg: Kyber NTT constants plus the modular add/subtract cells shared by the butterfly stages.
package ntt_butterfly_pipe_pkg;
    localparam int DW          = 12;
    localparam int Q           = 3329;
    localparam int BAR_M       = 5039;
    localparam int BAR_K       = 24;
    localparam int NTT_LATENCY = 3;
    localparam logic [DW-1:0] Q_DW = DW'(Q);

    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= {1'b0, Q_DW}) ? DW'(s - {1'b0, Q_DW}) : s[DW-1:0];
    endfunction

    // x + Q - y stays below Q when x < y, so DW-bit wraparound is harmless
    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return (x >= y) ? x - y : x + Q_DW - y;
    endfunction
endpackage

// File: rtl/ntt_butterfly_pipe_barrett_reduce.sv
// ntt_butterfly_pipe_barrett_reduce: combinational Barrett reduction of a product below Q^2 into 0..Q-1.
module ntt_butterfly_pipe_barrett_reduce
    import ntt_butterfly_pipe_pkg::*;
(
    input  logic [2*DW-1:0] p,
    output logic [DW-1:0]   t
);
    localparam int MW = 2*DW + 13;

    logic [MW-1:0]   prod;
    logic [2*DW-1:0] qh;
    logic [2*DW-1:0] r;

    // floor(2^24/Q) underestimates the quotient by at most one, so one correction suffices
    always_comb begin
        prod = MW'(p) * MW'(BAR_M);
        qh   = (2*DW)'(prod >> BAR_K);
        r    = p - qh * (2*DW)'(Q);
        t    = (r >= (2*DW)'(Q)) ? DW'(r - (2*DW)'(Q)) : DW'(r);
    end
endmodule

// File: rtl/ntt_butterfly_pipe.sv
// ntt_butterfly_pipe: 3-stage Cooley-Tukey butterfly with valid/ready and a global stall enable.
// Define NTT_GS_MODE_EN to add the in_mode port and the Gentleman-Sande inverse butterfly.
module ntt_butterfly_pipe
    import ntt_butterfly_pipe_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [DW-1:0] in_zeta,
`ifdef NTT_GS_MODE_EN
    input  logic          in_mode,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b
);
    logic            adv;
    logic            v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
    logic [2*DW-1:0] p_q, p_d;
    logic [DW-1:0]   a1_q, a1_d, a2_q, a2_d, t_q, t_d;
    logic [DW-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
    logic [DW-1:0]   a_in, mul_x, t_red, sum, dif;
`ifdef NTT_GS_MODE_EN
    logic            m1_q, m1_d, m2_q, m2_d;
`endif

    ntt_butterfly_pipe_barrett_reduce u_barrett (
        .p (p_q),
        .t (t_red)
    );

    always_comb begin
        adv   = !out_valid_q | out_ready;
        a_in  = in_a;
        mul_x = in_b;
        sum   = mod_add(a2_q, t_q);
        dif   = mod_sub(a2_q, t_q);
`ifdef NTT_GS_MODE_EN
        // GS folds a+b and a-b into stage 1 so the multiplier and reducer are shared with CT
        a_in  = in_mode ? mod_add(in_a, in_b) : in_a;
        mul_x = in_mode ? mod_sub(in_a, in_b) : in_b;
        sum   = m2_q ? a2_q : sum;
        dif   = m2_q ? t_q : dif;
        m1_d  = adv ? in_mode : m1_q;
        m2_d  = adv ? m1_q : m2_q;
`endif
        v1_d        = adv ? in_valid : v1_q;
        v2_d        = adv ? v1_q : v2_q;
        out_valid_d = adv ? v2_q : out_valid_q;
        p_d         = adv ? (2*DW)'(mul_x) * (2*DW)'(in_zeta) : p_q;
        a1_d        = adv ? a_in : a1_q;
        a2_d        = adv ? a1_q : a2_q;
        t_d         = adv ? t_red : t_q;
        out_a_d     = adv ? sum : out_a_q;
        out_b_d     = adv ? dif : out_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

    always_ff @(posedge clk) begin
        p_q  <= p_d;
        a1_q <= a1_d;
        a2_q <= a2_d;
        t_q  <= t_d;
`ifdef NTT_GS_MODE_EN
        m1_q <= m1_d;
        m2_q <= m2_d;
`endif
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// tb_ntt_butterfly_pipe: scoreboard bench for ntt_butterfly_pipe; random and directed butterflies vs an arithmetic model.
module tb_ntt_butterfly_pipe;
    import ntt_butterfly_pipe_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0, in_b = '0, in_zeta = '0;
`ifdef NTT_GS_MODE_EN
    logic          in_mode = 1'b0;
`endif
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_a, out_b;

    int checks = 0, failures = 0, cyc = 0, base = 0, rdy_mode = 0;

    typedef struct {int ea; int eb; int c; bit lat;} exp_t;
    exp_t sb[$];

    ntt_butterfly_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_zeta   (in_zeta),
`ifdef NTT_GS_MODE_EN
        .in_mode   (in_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int z, input bit m);
        exp_t e;
        int t;
        t = (z * b) % Q;
        e.ea = m ? (a + b) % Q : (a + t) % Q;
        e.eb = m ? (((a - b + Q) % Q) * z) % Q : (a - t + Q) % Q;
        e.c = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    task automatic send_exp(input int a, input int b, input int z, input bit m, input exp_t e);
        bit acc;
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_a = DW'(a);
        in_b = DW'(b);
        in_zeta = DW'(z);
`ifdef NTT_GS_MODE_EN
        in_mode = m;
`endif
        do begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                e.c = cyc;
                e.lat = (rdy_mode == 0);
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) chk("send_accept", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int z, input bit m);
        send_exp(a, b, z, m, model(a, b, z, m));
    endtask

    task automatic send_rand();
        bit m;
        m = 1'b0;
`ifdef NTT_GS_MODE_EN
        m = 1'($urandom_range(0, 1));
`endif
        send(int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), m);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 0) ? 1'b1 :
                        (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) :
                        !((cyc - base) >= 4 && (cyc - base) <= 6);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && !out_ready) chk("stall_in_ready", int'(in_ready), 0);
            else chk("in_ready", int'(in_ready), 1);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("out_a", int'(out_a), e.ea);
                    chk("out_b", int'(out_b), e.eb);
                    if (e.lat) chk("latency", cyc - e.c, NTT_LATENCY);
                end
            end
        end
    end

    initial begin
        exp_t k;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_a", int'(out_a), 0);
        chk("rst_out_b", int'(out_b), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("in_ready_after_rst", int'(in_ready), 1);
        idle(1);

        k.c = 0; k.lat = 1'b0;
        k.ea = 171;  k.eb = 29;   send_exp(100, 200, 17, 1'b0, k);
        k.ea = 1;    k.eb = 3328; send_exp(0, 3328, 3328, 1'b0, k);
        k.ea = 0;    k.eb = 3327; send_exp(3328, 1, 1, 1'b0, k);
        k.ea = 10;   k.eb = 0;    send_exp(5, 5, 1, 1'b0, k);
        k.ea = 105;  k.eb = 3234; send_exp(5, 100, 1, 1'b0, k);
`ifdef NTT_GS_MODE_EN
        k.ea = 15;   k.eb = 3319; send_exp(5, 10, 2, 1'b1, k);
        for (int i = 0; i < 12; i++) send(int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), 1'(i % 2));
`endif
        drain();

        rdy_mode = 2;
        base = cyc;
        for (int i = 0; i < 8; i++) send_rand();
        drain();
        rdy_mode = 0;
        idle(2);

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send_rand();
        end
        drain();
        rdy_mode = 0;
        idle(2);

        send_rand();
        send_rand();
        send_rand();
        chk("pre_rst_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_a", int'(out_a), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("in_ready_after_midrst", int'(in_ready), 1);
        idle(6);
        chk("no_stale_valid", int'(out_valid), 0);
        send(1234, 2345, 3001, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
